dmem_arbiter: RTL

//  Shares the single-port data RAM between two masters: m0 = cpu_core data port, m1 = loader/DMA port.

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/rr_arb2.sv | 8 +
 rtl/dmem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, access-size codes and latched-request type for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} arb_state_e;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef struct packed {
    logic owner;
    logic we;
  } arb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick; ports req[1:0], last (previous winner) -> win (winner id)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);
  assign win = &req ? ~last : req[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one sync data RAM by m0/m1 (req/we/addr/wdata/size in; gnt/rvalid/rdata out) via ram_* bus; DMEM_ARB_STATS_EN adds saturating mN_grant_cnt outputs
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef DMEM_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_size,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_size,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_store_size,
  output logic [1:0]        ram_load_size,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  m0_grant_cnt,
  output logic [CNT_W-1:0]  m1_grant_cnt
`endif
);
  arb_state_e state;
  arb_req_t lat;
  logic last, win, s_we;
  logic [1:0] s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, rdata0_q, rdata1_q;
  rr_arb2 u_pick (.req({m1_req, m0_req}), .last(last), .win(win));
  always_comb begin
    s_we    = win ? m1_we    : m0_we;
    s_size  = win ? m1_size  : m0_size;
    s_addr  = win ? m1_addr  : m0_addr;
    s_wdata = win ? m1_wdata : m0_wdata;
  end
  // RAM data arrives during RDWAIT; the owner sees it live that cycle and the copy holds afterwards
  assign m0_rdata = (state == RDWAIT && !lat.owner) ? ram_rdata : rdata0_q;
  assign m1_rdata = (state == RDWAIT &&  lat.owner) ? ram_rdata : rdata1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lat            <= '0;
      last           <= 1'b1;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_rvalid      <= 1'b0;
      m1_rvalid      <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_store_size <= SIZE_B;
      ram_load_size  <= SIZE_B;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        IDLE: if (m0_req || m1_req) begin
          lat            <= '{owner: win, we: s_we};
          last           <= win;
          m0_gnt         <= !win;
          m1_gnt         <= win;
          ram_we         <= s_we;
          ram_addr       <= s_addr;
          ram_wdata      <= s_wdata;
          ram_store_size <= s_we ? s_size : SIZE_B;
          ram_load_size  <= s_we ? SIZE_B : s_size;
          state          <= ISSUE;
        end
        ISSUE: begin
          m0_rvalid <= !lat.we && !lat.owner;
          m1_rvalid <= !lat.we &&  lat.owner;
          state     <= lat.we ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (lat.owner) rdata1_q <= ram_rdata;
          else rdata0_q <= ram_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
    end else begin
      if (m0_gnt && !(&m0_grant_cnt)) m0_grant_cnt <= m0_grant_cnt + 1'b1;
      if (m1_gnt && !(&m1_grant_cnt)) m1_grant_cnt <= m1_grant_cnt + 1'b1;
    end
  end
`endif
endmodule
